// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: funct3 codes, FSM states, the MEM/WB
// record, the bubble value and the access fault rule.
package mem_access_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_write;
    logic        fault;
  } mem_wb_t;

  localparam mem_wb_t OP_BUBBLE = '{result: 32'h0000_0000, rd: 5'd0,
                                    reg_write: 1'b0, fault: 1'b0};

  // An op faults when it is both load and store, uses an unsupported width,
  // or is not naturally aligned for its width.
  function automatic logic access_fault(input logic       rd_en,
                                        input logic       wr_en,
                                        input logic [2:0] f3,
                                        input logic [1:0] lane);
    logic f;
    f = 1'b0;
    if (rd_en && wr_en) begin
      f = 1'b1;
    end else if (rd_en) begin
      case (f3)
        F3_B, F3_BU: f = 1'b0;
        F3_H, F3_HU: f = lane[0];
        F3_W:        f = (lane != 2'b00);
        default:     f = 1'b1;
      endcase
    end else if (wr_en) begin
      case (f3)
        F3_B:    f = 1'b0;
        F3_H:    f = lane[0];
        F3_W:    f = (lane != 2'b00);
        default: f = 1'b1;
      endcase
    end else begin
      f = 1'b0;
    end
    return f;
  endfunction

endpackage

// File: rtl/mem_access_stage_dmem_be.sv
// Word-organised data memory with per-byte write enables: synchronous write,
// asynchronous read. Contents are deliberately not reset.
module dmem_be #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];

  // Byte-lane write; lanes whose enable is low keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: sub-word load/store, fault detection, multi-cycle access
// sequencing with stall/flush, and ownership of the MEM/WB register.
module mem_access_stage #(
  parameter int DMEM_DEPTH  = 256,
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] ex_mem_alu_result,
  input  logic [31:0] ex_mem_reg2,
  input  logic [4:0]  ex_mem_rd,
  input  logic        ex_mem_reg_write,
  input  logic        ex_mem_mem_read,
  input  logic        ex_mem_mem_write,
  input  logic [2:0]  ex_mem_funct3,
  output logic        mem_busy,
  output logic [31:0] mem_wb_result,
  output logic [4:0]  mem_wb_rd,
  output logic        mem_wb_reg_write,
  output logic        mem_wb_fault
);

  import mem_access_stage_pkg::*;

  localparam int         AW     = $clog2(DMEM_DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  // Pick the addressed byte/halfword out of the word and extend it.
  function automatic logic [31:0] load_align(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h00_0000, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Byte enables for a store of the given width at the given lane.
  function automatic logic [3:0] store_be(input logic [1:0] lane,
                                          input logic [2:0] f3);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the store data so every enabled lane sees the right bytes.
  function automatic logic [31:0] store_data(input logic [31:0] data,
                                             input logic [2:0]  f3);
    logic [31:0] d;
    case (f3)
      F3_B:    d = {4{data[7:0]}};
      F3_H:    d = {2{data[15:0]}};
      default: d = data;
    endcase
    return d;
  endfunction

  acc_state_t    state_r, state_nxt_s;
  logic [3:0]    cnt_r, cnt_nxt_s;
  mem_wb_t       wb_r, wb_nxt_s, wb_cap_s;
  logic          fault_s, access_s, finishing_s, mem_we_s;
  logic [1:0]    lane_s;
  logic [AW-1:0] word_addr_s;
  logic [31:0]   rdata_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;

  assign lane_s      = ex_mem_alu_result[1:0];
  assign word_addr_s = ex_mem_alu_result[AW+1:2];

  // Classify the op and decide whether it completes this cycle.
  always_comb begin
    fault_s  = access_fault(ex_mem_mem_read, ex_mem_mem_write, ex_mem_funct3, lane_s);
    access_s = (ex_mem_mem_read || ex_mem_mem_write) && !fault_s;
    if (!access_s) begin
      finishing_s = 1'b1;
    end else if (MEM_LATENCY == 1) begin
      finishing_s = 1'b1;
    end else if ((state_r == ST_WAIT) && (cnt_r == 4'd1)) begin
      finishing_s = 1'b1;
    end else begin
      finishing_s = 1'b0;
    end
    be_s     = store_be(lane_s, ex_mem_funct3);
    wdata_s  = store_data(ex_mem_reg2, ex_mem_funct3);
    mem_we_s = access_s && ex_mem_mem_write && finishing_s && !stall && !flush && !reset;
  end

  assign mem_busy = access_s && !finishing_s && !flush;

  dmem_be #(
    .DEPTH (DMEM_DEPTH)
  ) u_dmem (
    .clk   (clk),
    .we    (mem_we_s),
    .be    (be_s),
    .addr  (word_addr_s),
    .wdata (wdata_s),
    .rdata (rdata_s)
  );

  // Access FSM next state and wait counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (flush) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = 4'd0;
    end else if (stall) begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (access_s && !finishing_s) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = LAT_M1;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
          end
        end
        ST_WAIT: begin
          if (!access_s || finishing_s) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = cnt_r - 4'd1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end
      endcase
    end
  end

  // MEM/WB next value: capture on an unstalled finishing cycle, else bubble or hold.
  always_comb begin
    wb_cap_s.rd = ex_mem_rd;
    if (fault_s) begin
      wb_cap_s.result    = ex_mem_alu_result;
      wb_cap_s.reg_write = 1'b0;
      wb_cap_s.fault     = 1'b1;
    end else if (ex_mem_mem_read) begin
      wb_cap_s.result    = load_align(rdata_s, lane_s, ex_mem_funct3);
      wb_cap_s.reg_write = ex_mem_reg_write;
      wb_cap_s.fault     = 1'b0;
    end else begin
      wb_cap_s.result    = ex_mem_alu_result;
      wb_cap_s.reg_write = ex_mem_reg_write;
      wb_cap_s.fault     = 1'b0;
    end
    if (flush) begin
      wb_nxt_s = OP_BUBBLE;
    end else if (stall) begin
      wb_nxt_s = wb_r;
    end else if (finishing_s) begin
      wb_nxt_s = wb_cap_s;
    end else begin
      wb_nxt_s = OP_BUBBLE;
    end
  end

  // State, counter and MEM/WB registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      wb_r    <= OP_BUBBLE;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      wb_r    <= wb_nxt_s;
    end
  end

  assign mem_wb_result    = wb_r.result;
  assign mem_wb_rd        = wb_r.rd;
  assign mem_wb_reg_write = wb_r.reg_write;
  assign mem_wb_fault     = wb_r.fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: two instances (latency 1 and 3) run
// the same op list against a byte-array reference model.
`timescale 1ns/1ps
module tb_mem_access_stage;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        re;
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  stall_mask;
    int          flush_at;
    int          reset_at;
  } op_t;

  typedef struct {
    logic        busy;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        flt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_v [2];
  logic        stall_v [2];
  logic        flush_v [2];
  logic [31:0] alu_v   [2];
  logic [31:0] data_v  [2];
  logic [4:0]  rd_v    [2];
  logic        rw_v    [2];
  logic        re_v    [2];
  logic        we_v    [2];
  logic [2:0]  f3_v    [2];
  logic        busy_o  [2];
  logic [31:0] res_o   [2];
  logic [4:0]  rd_o    [2];
  logic        rw_o    [2];
  logic        flt_o   [2];

  mem_access_stage #(.DMEM_DEPTH(256), .MEM_LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset_v[0]), .stall(stall_v[0]), .flush(flush_v[0]),
    .ex_mem_alu_result(alu_v[0]), .ex_mem_reg2(data_v[0]), .ex_mem_rd(rd_v[0]),
    .ex_mem_reg_write(rw_v[0]), .ex_mem_mem_read(re_v[0]), .ex_mem_mem_write(we_v[0]),
    .ex_mem_funct3(f3_v[0]), .mem_busy(busy_o[0]), .mem_wb_result(res_o[0]),
    .mem_wb_rd(rd_o[0]), .mem_wb_reg_write(rw_o[0]), .mem_wb_fault(flt_o[0]));

  mem_access_stage #(.DMEM_DEPTH(256), .MEM_LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset_v[1]), .stall(stall_v[1]), .flush(flush_v[1]),
    .ex_mem_alu_result(alu_v[1]), .ex_mem_reg2(data_v[1]), .ex_mem_rd(rd_v[1]),
    .ex_mem_reg_write(rw_v[1]), .ex_mem_mem_read(re_v[1]), .ex_mem_mem_write(we_v[1]),
    .ex_mem_funct3(f3_v[1]), .mem_busy(busy_o[1]), .mem_wb_result(res_o[1]),
    .mem_wb_rd(rd_o[1]), .mem_wb_reg_write(rw_o[1]), .mem_wb_fault(flt_o[1]));

  int         total = 0;
  int         bad   = 0;
  op_t        ops[$];
  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] mb [2][1024];
  int         lat    [2] = '{1, 3};
  int         op_idx [2] = '{0, 0};
  int         cyc    [2] = '{0, 0};
  int         rem    [2] = '{1, 1};
  exp_t       prev   [2];
  exp_t       pend   [2];
  logic       pend_v [2] = '{1'b0, 1'b0};

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t: got %h want %h", name, d, $time, act, exp);
    end
  endtask

  function automatic op_t mk(input logic re, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic rw, input logic [4:0] rd);
    op_t o;
    o.re = re; o.we = we; o.f3 = f3; o.addr = addr; o.data = data;
    o.rw = rw; o.rd = rd; o.stall_mask = 8'h00; o.flush_at = -1; o.reset_at = -1;
    return o;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.busy = 1'b0; e.res = 32'h0; e.rd = 5'd0; e.rw = 1'b0; e.flt = 1'b0;
    return e;
  endfunction

  function automatic logic is_fault(input op_t o);
    logic [1:0] a;
    a = o.addr[1:0];
    if (o.re && o.we) return 1'b1;
    if (o.re && !(o.f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b1;
    if (o.we && !(o.f3 inside {3'b000, 3'b001, 3'b010})) return 1'b1;
    if (!(o.re || o.we)) return 1'b0;
    if (o.f3[1:0] == 2'b01 && a[0]) return 1'b1;
    if (o.f3[1:0] == 2'b10 && a != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  // Completion of an op in the model: byte-addressed memory, little-endian.
  task automatic capture(input int d, input op_t o, output exp_t e);
    int b;
    logic [15:0] h;
    logic [31:0] w;
    b = int'(o.addr[9:0]);
    e = zero_exp();
    e.rd = o.rd;
    if (is_fault(o)) begin
      e.res = o.addr; e.flt = 1'b1; e.rw = 1'b0;
    end else if (o.re) begin
      e.rw = o.rw;
      h = {mb[d][(b+1)%1024], mb[d][b]};
      w = {mb[d][(b+3)%1024], mb[d][(b+2)%1024], h};
      case (o.f3)
        3'b000:  e.res = {{24{mb[d][b][7]}}, mb[d][b]};
        3'b100:  e.res = {24'h0, mb[d][b]};
        3'b001:  e.res = {{16{h[15]}}, h};
        3'b101:  e.res = {16'h0, h};
        default: e.res = w;
      endcase
    end else begin
      e.rw  = o.rw;
      e.res = o.addr;
      if (o.we) begin
        for (int i = 0; i < (1 << o.f3[1:0]); i++) begin
          w = o.data >> (8 * i);
          mb[d][b + i] = w[7:0];
        end
      end
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drive_idle(input int d, input logic rst);
    reset_v[d] = rst; stall_v[d] = 1'b0; flush_v[d] = 1'b0;
    alu_v[d] = 32'h0; data_v[d] = 32'h0; rd_v[d] = 5'd0; rw_v[d] = 1'b0;
    re_v[d] = 1'b0; we_v[d] = 1'b0; f3_v[d] = 3'b000;
  endtask

  // One cycle of stimulus for DUT d plus the model's expectation for it.
  task automatic step(input int d);
    op_t  o;
    exp_t e;
    logic acc, done;
    done = 1'b0;
    if (op_idx[d] >= ops.size()) begin
      drive_idle(d, 1'b0);
      e = zero_exp();
      prev[d] = e;
      push(d, e);
      return;
    end
    o = ops[op_idx[d]];
    acc = (o.re || o.we) && !is_fault(o);
    if (cyc[d] == 0) rem[d] = acc ? lat[d] : 1;
    drive_idle(d, 1'b0);
    alu_v[d] = o.addr; data_v[d] = o.data; rd_v[d] = o.rd; rw_v[d] = o.rw;
    re_v[d] = o.re; we_v[d] = o.we; f3_v[d] = o.f3;
    if (o.reset_at == cyc[d]) begin
      drive_idle(d, 1'b1);
      e = zero_exp();
      done = 1'b1;
    end else if (o.flush_at == cyc[d]) begin
      flush_v[d] = 1'b1;
      stall_v[d] = 1'($urandom_range(0, 1));
      e = zero_exp();
      done = 1'b1;
    end else if (cyc[d] < 8 && o.stall_mask[cyc[d]]) begin
      stall_v[d] = 1'b1;
      e = prev[d];
      e.busy = acc && (rem[d] > 1);
    end else if (rem[d] > 1) begin
      e = zero_exp();
      e.busy = 1'b1;
      rem[d]--;
    end else begin
      capture(d, o, e);
      done = 1'b1;
    end
    prev[d] = e;
    push(d, e);
    cyc[d]++;
    if (done) begin
      op_idx[d]++;
      cyc[d] = 0;
    end
  endtask

  // Monitor: busy is checked in its own cycle, MEM/WB one edge later.
  initial begin
    exp_t r;
    logic have;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        have = 1'b0;
        if (d == 0 && q0.size() > 0) begin
          r = q0.pop_front(); have = 1'b1;
        end else if (d == 1 && q1.size() > 0) begin
          r = q1.pop_front(); have = 1'b1;
        end
        if (have) begin
          check("mem_busy", d, {31'b0, busy_o[d]}, {31'b0, r.busy});
          if (pend_v[d]) begin
            check("wb_result", d, res_o[d], pend[d].res);
            check("wb_rd", d, {27'b0, rd_o[d]}, {27'b0, pend[d].rd});
            check("wb_reg_write", d, {31'b0, rw_o[d]}, {31'b0, pend[d].rw});
            check("wb_fault", d, {31'b0, flt_o[d]}, {31'b0, pend[d].flt});
          end
          pend[d]   = r;
          pend_v[d] = 1'b1;
        end
      end
    end
  end

  initial begin
    op_t        t;
    logic [31:0] r;
    logic [3:0]  w4;
    logic [1:0]  lane;
    int          k, cycles;

    drive_idle(0, 1'b1);
    drive_idle(1, 1'b1);

    for (int w = 0; w < 16; w++) ops.push_back(mk(1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom(), 1'b0, 5'd0));
    ops.push_back(mk(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 5'd0));
    ops.push_back(mk(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 1'b1, 5'd1));
    ops.push_back(mk(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 1'b1, 5'd2));
    ops.push_back(mk(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 5'd3));
    ops.push_back(mk(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 1'b1, 5'd4));
    ops.push_back(mk(1'b0, 1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 1'b0, 5'd0));
    ops.push_back(mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 5'd5));
    ops.push_back(mk(1'b0, 1'b1, 3'b001, 32'h12, 32'hABCD1234, 1'b0, 5'd0));
    ops.push_back(mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 5'd6));
    ops.push_back(mk(1'b1, 1'b0, 3'b010, 32'h02, 32'h0, 1'b1, 5'd7));
    ops.push_back(mk(1'b0, 1'b1, 3'b001, 32'h01, 32'h77777777, 1'b1, 5'd8));
    ops.push_back(mk(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 5'd9));
    ops.push_back(mk(1'b0, 1'b1, 3'b100, 32'h14, 32'h88888888, 1'b0, 5'd10));
    ops.push_back(mk(1'b1, 1'b1, 3'b010, 32'h14, 32'h99999999, 1'b1, 5'd11));
    ops.push_back(mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 5'd12));
    ops.push_back(mk(1'b0, 1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, 1'b0, 5'd0));
    ops.push_back(mk(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 5'd13));
    ops.push_back(mk(1'b0, 1'b0, 3'b000, 32'h3, 32'h0, 1'b1, 5'd14));
    ops.push_back(mk(1'b0, 1'b1, 3'b010, 32'h400, 32'h0BADF00D, 1'b0, 5'd0));
    ops.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1, 5'd15));
    t = mk(1'b0, 1'b1, 3'b010, 32'h24, 32'h600DCAFE, 1'b0, 5'd0);
    t.stall_mask = 8'b0000_0110;
    ops.push_back(t);
    ops.push_back(mk(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 1'b1, 5'd16));
    t = mk(1'b0, 1'b1, 3'b010, 32'h28, 32'h11112222, 1'b0, 5'd0);
    t.flush_at = 1;
    ops.push_back(t);
    ops.push_back(mk(1'b1, 1'b0, 3'b010, 32'h28, 32'h0, 1'b1, 5'd17));
    t = mk(1'b0, 1'b1, 3'b010, 32'h2C, 32'h33334444, 1'b0, 5'd0);
    t.flush_at = 0;
    ops.push_back(t);
    ops.push_back(mk(1'b1, 1'b0, 3'b010, 32'h2C, 32'h0, 1'b1, 5'd18));
    t = mk(1'b0, 1'b1, 3'b010, 32'h30, 32'h55556666, 1'b0, 5'd0);
    t.reset_at = 1;
    ops.push_back(t);
    ops.push_back(mk(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 1'b1, 5'd19));
    t = mk(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 5'd20);
    t.stall_mask = 8'b0000_0011;
    ops.push_back(t);

    for (int n = 0; n < 200; n++) begin
      r  = $urandom();
      k  = $urandom_range(0, 9);
      w4 = 4'($urandom_range(0, 15));
      t  = mk(1'b0, 1'b0, 3'b000, r, $urandom(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      if (k < 4) begin
        t.re = 1'b1; t.f3 = 3'($urandom_range(0, 7));
      end else if (k < 8) begin
        t.we = 1'b1;
        t.f3 = ($urandom_range(0, 9) == 0) ? 3'b011 : 3'($urandom_range(0, 2));
      end else if (k == 8) begin
        t.re = 1'b1; t.we = 1'b1; t.f3 = 3'b010;
      end
      if (t.re || t.we) begin
        if ($urandom_range(0, 4) == 0) lane = 2'($urandom_range(0, 3));
        else if (t.f3[1:0] == 2'b10) lane = 2'b00;
        else if (t.f3[1:0] == 2'b01) lane = {1'($urandom_range(0, 1)), 1'b0};
        else lane = 2'($urandom_range(0, 3));
        t.addr = {r[31:10], 4'b0000, w4, lane};
      end
      for (int i = 0; i < 8; i++) t.stall_mask[i] = ($urandom_range(0, 5) == 0);
      t.flush_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1;
      ops.push_back(t);
    end

    repeat (3) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        drive_idle(d, 1'b1);
        push(d, zero_exp());
        prev[d] = zero_exp();
      end
    end

    cycles = 0;
    while ((op_idx[0] < ops.size() || op_idx[1] < ops.size()) && cycles < 20000) begin
      @(posedge clk); #1;
      step(0);
      step(1);
      cycles++;
    end
    check("cycle_budget", 0, 32'(cycles >= 20000), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      step(0);
      step(1);
    end
    @(negedge clk); #2;
    check("q_drain", 0, 32'(q0.size()), 32'd0);
    check("q_drain", 1, 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
